riscv_hazard_ctrl: RTL

- Pipeline sequencer for the 5-stage RV32I core (FD, DE, EM and MW pipeline registers).
- Generates enable/clear for each pipeline register and the PC, and EX-stage operand forwarding selects.
- Owns a small FSM that freezes the pipeline while a multi-cycle data-memory access in MM is outstanding.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/riscv_hazard_ctrl_pkg.sv | 20 ++
 rtl/riscv_fwd_unit.sv | 21 ++
 rtl/riscv_hazard_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared encodings for the RV32I pipeline sequencer: rd-source selects,
// forwarding selects and hazard-FSM states.
package riscv_hazard_ctrl_pkg;

   localparam logic [1:0] SRC_RD_ALU  = 2'b00;
   localparam logic [1:0] SRC_RD_LOAD = 2'b01;
   localparam logic [1:0] SRC_RD_PC4  = 2'b10;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_WB = 2'b01,
      FWD_MM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/riscv_fwd_unit.sv
// EX-stage operand forwarding compare for one source register; MM wins over WB.
module riscv_fwd_unit
   import riscv_hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs_addr,
   input  logic [4:0] mm_rd_addr,
   input  logic       mm_reg_wr_en,
   input  logic [4:0] wb_rd_addr,
   input  logic       wb_reg_wr_en,
   output fwd_sel_e   fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      if (mm_reg_wr_en && (mm_rd_addr != 5'd0) && (mm_rd_addr == rs_addr))
         fwd_sel = FWD_MM;
      else if (wb_reg_wr_en && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs_addr))
         fwd_sel = FWD_WB;
   end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: register enables/clears,
// operand forwarding, data-memory wait FSM and a saturating stall counter.
module riscv_hazard_ctrl
   import riscv_hazard_ctrl_pkg::*;
#(
   parameter logic [1:0]  SRC_RD_MEM  = SRC_RD_LOAD,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [4:0]       i_de_rs1_addr,
   input  logic [4:0]       i_de_rs2_addr,
   input  logic [4:0]       i_ex_rs1_addr,
   input  logic [4:0]       i_ex_rs2_addr,
   input  logic [4:0]       i_ex_rd_addr,
   input  logic [1:0]       i_ex_src_rd,
   input  logic             i_ex_reg_wr_en,
   input  logic             i_ex_branch_taken,
   input  logic [4:0]       i_mm_rd_addr,
   input  logic             i_mm_reg_wr_en,
   input  logic [4:0]       i_wb_rd_addr,
   input  logic             i_wb_reg_wr_en,
   input  logic             i_mm_mem_req,
   input  logic             i_mm_mem_ack,
   output logic             o_pc_en,
   output logic             o_fd_en,
   output logic             o_fd_clear,
   output logic             o_de_en,
   output logic             o_de_clear,
   output logic             o_em_en,
   output logic             o_mw_en,
   output logic             o_mw_clear,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic             o_mem_err,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   hz_state_e        state_q, state_d;
   logic [7:0]       wait_q;
   logic             mem_err_q;
   logic [CNT_W-1:0] stall_q;
   logic             mem_pending, wait_expired, timeout;
   logic             freeze, branch, load_use;
   fwd_sel_e         sel_a, sel_b;

   assign mem_pending  = i_mm_mem_req & ~i_mm_mem_ack;
   assign wait_expired = (state_q == ST_MEM_WAIT) && (wait_q == WAIT_LAST);
   assign timeout      = wait_expired & ~i_mm_mem_ack;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (mem_pending) state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: if (i_mm_mem_ack || wait_expired) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Hazard terms are gated by reset so the pipeline sees plain "run" while held.
   assign freeze   = i_rstn & ((state_q == ST_MEM_WAIT) | ((state_q == ST_IDLE) & mem_pending));
   assign branch   = i_rstn & i_ex_branch_taken;
   assign load_use = i_rstn && (i_ex_src_rd == SRC_RD_MEM) && i_ex_reg_wr_en
                     && (i_ex_rd_addr != 5'd0)
                     && ((i_ex_rd_addr == i_de_rs1_addr) || (i_ex_rd_addr == i_de_rs2_addr));

   always_comb begin
      o_pc_en    = 1'b1;
      o_fd_en    = 1'b1;
      o_fd_clear = 1'b0;
      o_de_en    = 1'b1;
      o_de_clear = 1'b0;
      o_em_en    = 1'b1;
      o_mw_en    = 1'b1;
      o_mw_clear = 1'b0;
      if (freeze) begin
         o_pc_en    = 1'b0;
         o_fd_en    = 1'b0;
         o_de_en    = 1'b0;
         o_em_en    = 1'b0;
         o_mw_clear = 1'b1;
      end else if (branch) begin
         o_fd_clear = 1'b1;
         o_de_clear = 1'b1;
      end else if (load_use) begin
         o_pc_en    = 1'b0;
         o_fd_en    = 1'b0;
         o_de_clear = 1'b1;
      end
   end

   riscv_fwd_unit u_fwd_a (
      .rs_addr      (i_ex_rs1_addr),
      .mm_rd_addr   (i_mm_rd_addr),
      .mm_reg_wr_en (i_mm_reg_wr_en),
      .wb_rd_addr   (i_wb_rd_addr),
      .wb_reg_wr_en (i_wb_reg_wr_en),
      .fwd_sel      (sel_a)
   );

   riscv_fwd_unit u_fwd_b (
      .rs_addr      (i_ex_rs2_addr),
      .mm_rd_addr   (i_mm_rd_addr),
      .mm_reg_wr_en (i_mm_reg_wr_en),
      .wb_rd_addr   (i_wb_rd_addr),
      .wb_reg_wr_en (i_wb_reg_wr_en),
      .fwd_sel      (sel_b)
   );

   assign o_fwd_a = i_rstn ? sel_a : FWD_RF;
   assign o_fwd_b = i_rstn ? sel_b : FWD_RF;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= (state_q == ST_MEM_WAIT) ? wait_q + 8'd1 : '0;
         mem_err_q <= timeout;
         if (!o_pc_en && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
      end
   end

   assign o_mem_err   = mem_err_q;
   assign o_stall_cnt = stall_q;

endmodule
